// File: rtl/alu_seq.sv
// alu_seq: clocked 8-op ALU with valid/ready handshakes on both sides.
// ADD/SUB/logic ops and divide-by-zero finish at the accept edge.
// MUL (shift-add) and DIV (restoring) take one bit per cycle.
module alu_seq #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            oc,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] f,
  output logic [DATA_WIDTH-1:0] hi,
  output logic                  flag_z,
  output logic                  flag_c,
  output logic                  flag_v,
  output logic                  flag_dz
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_MUL = 3'b010, OP_DIV = 3'b011,
    OP_NOT = 3'b100, OP_XOR = 3'b101, OP_OR  = 3'b110, OP_AND = 3'b111
  } op_e;

  state_e         r_state, w_next;
  logic [CW-1:0]  r_cnt;
  logic           r_is_div;
  logic [W-1:0]   r_p;      // MUL: running upper half; DIV: partial remainder
  logic [W-1:0]   r_q;      // MUL: multiplier / low half; DIV: dividend / quotient
  logic [W-1:0]   r_d;      // MUL: multiplicand; DIV: divisor
  logic [W-1:0]   r_f, r_hi;
  logic           r_z, r_c, r_v, r_dz;

  op_e            w_op;
  logic           w_multi;
  logic [W:0]     w_add, w_sub;
  logic [W-1:0]   w_f1, w_hi1;
  logic           w_c1, w_v1, w_dz1;

  logic [W:0]     w_sum;
  logic [W-1:0]   w_mul_p, w_mul_q;
  logic [W:0]     w_rs;
  logic           w_ge;
  logic [W-1:0]   w_dsub, w_div_p, w_div_q;

  assign w_op    = op_e'(oc);
  assign w_multi = (w_op == OP_MUL) || ((w_op == OP_DIV) && (b != '0));
  assign w_add   = {1'b0, a} + {1'b0, b};
  assign w_sub   = {1'b0, a} - {1'b0, b};

  // Shift-add step: conditionally add multiplicand, shift {p,q} right by one
  assign w_sum   = {1'b0, r_p} + (r_q[0] ? {1'b0, r_d} : '0);
  assign w_mul_p = w_sum[W:1];
  assign w_mul_q = {w_sum[0], r_q[W-1:1]};

  // Restoring step: shift in next dividend bit, subtract divisor if it fits.
  // The difference is kept to W bits since it is only used when it fits.
  assign w_rs    = {r_p, r_q[W-1]};
  assign w_ge    = (w_rs >= {1'b0, r_d});
  assign w_dsub  = w_rs[W-1:0] - r_d;
  assign w_div_p = w_ge ? w_dsub : w_rs[W-1:0];
  assign w_div_q = {r_q[W-2:0], w_ge};

  // Single-cycle result from the live operands at the accept edge
  always_comb begin
    w_f1  = '0;
    w_hi1 = '0;
    w_c1  = 1'b0;
    w_v1  = 1'b0;
    w_dz1 = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_f1 = w_add[W-1:0];
        w_c1 = w_add[W];
        w_v1 = (a[W-1] == b[W-1]) && (w_add[W-1] != a[W-1]);
      end
      OP_SUB: begin
        w_f1 = w_sub[W-1:0];
        w_c1 = w_sub[W];
        w_v1 = (a[W-1] != b[W-1]) && (w_sub[W-1] != a[W-1]);
      end
      OP_DIV: begin
        w_f1  = '1;
        w_hi1 = a;
        w_dz1 = 1'b1;
      end
      OP_NOT: w_f1 = ~a;
      OP_XOR: w_f1 = a ^ b;
      OP_OR:  w_f1 = a | b;
      OP_AND: w_f1 = a & b;
      OP_MUL: w_f1 = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_next = w_multi ? S_BUSY : S_DONE;
      S_BUSY: if (r_cnt == '0) w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result registers written on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_p      <= '0;
      r_q      <= '0;
      r_d      <= '0;
      r_f      <= '0;
      r_hi     <= '0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          if (w_multi) begin
            r_cnt    <= CW'(W - 1);
            r_p      <= '0;
            r_is_div <= (w_op == OP_DIV);
            r_q      <= (w_op == OP_DIV) ? a : b;
            r_d      <= (w_op == OP_DIV) ? b : a;
          end else begin
            r_f  <= w_f1;
            r_hi <= w_hi1;
            r_z  <= (w_f1 == '0);
            r_c  <= w_c1;
            r_v  <= w_v1;
            r_dz <= w_dz1;
          end
        end
        S_BUSY: begin
          r_p <= r_is_div ? w_div_p : w_mul_p;
          r_q <= r_is_div ? w_div_q : w_mul_q;
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_f  <= r_is_div ? w_div_q : w_mul_q;
            r_hi <= r_is_div ? w_div_p : w_mul_p;
            r_z  <= r_is_div ? (w_div_q == '0) : (w_mul_q == '0);
            r_c  <= r_is_div ? 1'b0 : (w_mul_p != '0);
            r_v  <= 1'b0;
            r_dz <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign f         = r_f;
  assign hi        = r_hi;
  assign flag_z    = r_z;
  assign flag_c    = r_c;
  assign flag_v    = r_v;
  assign flag_dz   = r_dz;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed cases plus a randomized sweep against an arithmetic reference model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  oc = '0;
  logic [15:0] a = '0, b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] f, hi;
  logic        flag_z, flag_c, flag_v, flag_dz;

  int n_tests = 0;
  int n_fail  = 0;

  alu_seq #(.DATA_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .oc(oc), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .f(f), .hi(hi), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .flag_dz(flag_dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic; flags packed {z,c,v,dz}
  function automatic void model(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                                output logic [15:0] ef, output logic [15:0] ehi,
                                output logic [3:0] efl, output int lat);
    logic [31:0] p;
    int sx, sy, sr;
    logic c, v, dz;
    ehi = '0; c = 0; v = 0; dz = 0; lat = 1; ef = '0;
    sx = int'($signed(x));
    sy = int'($signed(y));
    case (op)
      3'd0: begin
        p  = 32'(x) + 32'(y);
        ef = p[15:0];
        c  = (p > 32'hFFFF);
        sr = sx + sy;
        v  = (sr > 32767) || (sr < -32768);
      end
      3'd1: begin
        ef = x - y;
        c  = (x < y);
        sr = sx - sy;
        v  = (sr > 32767) || (sr < -32768);
      end
      3'd2: begin
        p   = 32'(x) * 32'(y);
        ef  = p[15:0];
        ehi = p[31:16];
        c   = (ehi != 0);
        lat = 17;
      end
      3'd3: begin
        if (y == 0) begin
          ef = 16'hFFFF; ehi = x; dz = 1;
        end else begin
          ef = x / y; ehi = x % y; lat = 17;
        end
      end
      3'd4: ef = ~x;
      3'd5: ef = x ^ y;
      3'd6: ef = x | y;
      default: ef = x & y;
    endcase
    efl = {(ef == 0), c, v, dz};
  endfunction

  // One full transaction: accept, latency, result, backpressure hold, release
  task automatic do_op(input logic [2:0] op, input logic [15:0] ia, input logic [15:0] ib,
                       input logic [15:0] ef, input logic [15:0] ehi, input logic [3:0] efl,
                       input int elat, input int hold);
    int lat;
    int w;
    w = 0;
    while (!in_ready && w < 40) begin
      @(negedge clk); w++;
    end
    if (!in_ready) check("in_ready_wait", 0, 1);
    oc = op; a = ia; b = ib; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); oc = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      check("in_ready_busy", in_ready, 0);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, elat);
    check("f", f, ef);
    check("hi", hi, ehi);
    check("flags", {flag_z, flag_c, flag_v, flag_dz}, efl);
    check("in_ready_done", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      oc = 3'($urandom); a = 16'($urandom); b = 16'($urandom);
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_f", {hi, f, flag_z, flag_c, flag_v, flag_dz}, {ehi, ef, efl});
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_ready", in_ready, 1);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h0001;
      3: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [15:0] ef, ehi, ra, rb;
    logic [3:0]  efl;
    logic [2:0]  rop;
    int lat;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_state", {in_ready, out_valid, f, hi, flag_z, flag_c, flag_v, flag_dz},
          {1'b1, 1'b0, 32'h0, 4'h0});
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    do_op(3'd0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b1100, 1, 0);
    do_op(3'd1, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 4'b0010, 1, 0);
    do_op(3'd2, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 4'b0100, 17, 0);
    do_op(3'd3, 16'd100,  16'd7,    16'h000E, 16'h0002, 4'b0000, 17, 0);
    do_op(3'd3, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 4'b0001, 1, 0);
    do_op(3'd5, 16'h00FF, 16'h0F0F, 16'h0FF0, 16'h0000, 4'b0000, 1, 10);

    // Asynchronous reset in the middle of a MUL
    oc = 3'd2; a = 16'h1234; b = 16'h0100; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_mid", {in_ready, out_valid, f, hi, flag_z, flag_c, flag_v, flag_dz},
             {1'b1, 1'b0, 32'h0, 4'h0});
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("no_stale", {out_valid, in_ready}, 2'b01);
    end

    // Random sweep with idle gaps and backpressure
    for (int n = 0; n < 3000; n++) begin
      rop = 3'($urandom);
      ra  = pick();
      rb  = pick();
      model(rop, ra, rb, ef, ehi, efl, lat);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        @(negedge clk);
        check("idle_no_out", out_valid, 0);
      end
      do_op(rop, ra, rb, ef, ehi, efl, lat, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
